tmul_mac_seq: RTL and testbench
===============================

# tmul_mac_seq

- Sequential, parametrised tile multiply-accumulate engine for the TMUL datapath.
- Accepts a streamed tile one reduction step per beat: one A scalar plus one B row of N elements.
- Keeps N accumulator lanes, each updated as acc[i] += a_k * b_k[i].
- Presents the finished N-lane result on a valid/ready output port, so the array multiplier becomes a pipelined, back-pressurable stage between operand fetch and result write-back.

## Interface
- DW, 32, operand element width (A scalar and each B element).
- N, 8, number of B elements per row = number of output lanes.
- K, 8, maximum beats per tile (reduction depth).
- ACCW, 2*DW+$clog2(K), accumulator/result lane width (derived; do not override).
- clk  in  1  rising-edge clock; single clock domain.
- rst  in  1  synchronous reset, active-low; sampled on rising clk.
- in_valid  in  1  input beat valid.
- in_ready  out  1  engine accepts a beat this cycle.
- in_a  in  DW  A scalar for this reduction step.
- in_b  in  N*DW  B row; element i at bits [i*DW+DW-1 : i*DW].
- in_last  in  1  final beat of the tile.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- out_data  out  N*ACCW  result lanes; lane i at bits [i*ACCW+ACCW-1 : i*ACCW].
- out_cnt  out  $clog2(K+1)  number of beats accumulated into out_data.

## Operation
- Beat accepted when in_valid && in_ready at a rising edge.
- Stage 1 (product register): on acceptance, register N products a*b[i], extended to ACCW bits, plus a prod_vld flag.
- Stage 2 (accumulate): when prod_vld is set, acc[i] += prod[i] and beat counter += 1.
- FSM states:
  - ACC: in_ready=1, out_valid=0.
    - Accepted beat with in_last=1 goes to FLUSH.
    - Accepted beat that is the K-th beat of the tile goes to FLUSH even if in_last=0 (forced last).
  - FLUSH: in_ready=0, out_valid=0. Final product accumulates. Unconditional move to HOLD after one cycle.
  - HOLD: in_ready=0, out_valid=1.
    - out_data = acc, out_cnt = beat counter; both stable until handshake.
    - On out_ready: clear acc and counter, go to ACC.
- Arithmetic: unsigned by default; products zero-extended. ACCW never overflows for up to K beats.
- in_valid gaps inside a tile are allowed and do not affect the result.
- Reset (rst=0 at an edge), including mid-tile or in HOLD:
  - State becomes ACC.
  - acc, counter and prod_vld clear to 0; the partial tile is discarded.
  - While rst=0: in_ready=0, out_valid=0, out_data=0, out_cnt=0.
- No overlap of tiles: a new tile cannot be accepted until the previous result handshakes.

## Timing
- Last beat accepted at edge E0 → acc final at E1 → out_valid=1 in the cycle after E1 (2-cycle latency).
- Earliest first beat of the next tile is at the edge after the out handshake.
- Peak throughput: 1 beat/cycle within a tile.
- Per-tile overhead: 2 cycles plus the output handshake.

## Configuration
- TMUL_SIGNED_EN defined:
  - Adds port in_signed (in, 1).
  - in_signed is sampled on the first beat of a tile and held for the tile.
  - When in_signed=1, operands are two's complement and products are sign-extended to ACCW.
- TMUL_SIGNED_EN undefined:
  - No in_signed port.
  - Unsigned arithmetic only.

## Test plan
- Defaults, 8 beats back-to-back, beat k (0..7) a=k+1, every b element of row k = i+1 for lane i, in_last on beat 7 → lane i = 36*(i+1), out_cnt=8, out_valid high exactly 2 cycles after the last acceptance edge.
- Early last: 3 beats a=1,2,3, b lane i = i+1, in_last on beat 3 → lane i = 6*(i+1), out_cnt=3.
- Width boundary: 8 beats, a=b=0xFFFFFFFF, unsigned → every lane = 0x7_FFFF_FFF0_0000_0008 (67 bits), no truncation.
- Forced last: 8 beats with in_last=0 → HOLD after beat 8, in_ready=0; a 9th beat offered is not accepted.
- Backpressure: out_ready low for 5 cycles in HOLD → out_valid/out_data/out_cnt stable, in_ready=0. Next tile (a=1, b=1, 1 beat) → lanes = 1, proving the clear.
- Reset and signed:
  - rst=0 for one cycle after 4 beats → all outputs 0; the following full tile from scenario 1 yields the scenario 1 values.
  - With TMUL_SIGNED_EN, 8 beats a=0xFFFFFFFF, b=2: in_signed=1 → lanes = -16 (two's complement, ACCW); in_signed=0 → lanes = 0xF_FFFF_FFF0.

Source files
------------

// File: rtl/tmul_mac_seq.sv
// tmul_mac_seq: sequential N-lane tile multiply-accumulate engine.
// A tile is streamed as one A scalar plus one B row per beat. Each beat goes
// through a product register stage and then an accumulate stage. The finished
// lanes are then held on a valid/ready output port until the consumer takes them.
// Optional build macro: TMUL_SIGNED_EN adds in_signed for two's complement tiles.

// One output lane: product register followed by the accumulator.
module tmul_mac_lane #(
    parameter int DW   = 32,
    parameter int ACCW = 67
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            take,
    input  logic            add,
    input  logic            clr,
    input  logic            sg,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic [ACCW-1:0] acc
);
    logic [2*DW-1:0] p;
    logic [ACCW-1:0] prod;

    // The low 2*DW bits of the product of the extended operands are the exact
    // product in both modes. A signed product always fits in 2*DW bits.
    assign p = {{DW{sg & a[DW-1]}}, a} * {{DW{sg & b[DW-1]}}, b};

    // Register the extended product on acceptance, then fold it into acc.
    always_ff @(posedge clk) begin
        if (!rst) begin
            prod <= '0;
            acc  <= '0;
        end else begin
            if (take)
                prod <= {{(ACCW-2*DW){sg & p[2*DW-1]}}, p};
            if (clr)
                acc <= '0;
            else if (add)
                acc <= acc + prod;
        end
    end
endmodule

module tmul_mac_seq #(
    parameter  int DW   = 32,
    parameter  int N    = 8,
    parameter  int K    = 8,
    localparam int ACCW = 2*DW + $clog2(K),
    localparam int CW   = $clog2(K+1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_a,
    input  logic [N*DW-1:0] in_b,
    input  logic            in_last,
`ifdef TMUL_SIGNED_EN
    input  logic            in_signed,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*ACCW-1:0] out_data,
    output logic [CW-1:0]   out_cnt
);
    typedef enum logic [1:0] {S_ACC, S_FLUSH, S_HOLD} state_t;

    state_t                    state;
    logic                      rdy_r, vld_r, prod_vld;
    logic [CW-1:0]             in_cnt, acc_cnt;
    logic                      take, clr, sg_cur;
    logic [N-1:0][ACCW-1:0]    acc;

    // Outputs are forced quiet while reset is held, not only after the reset edge.
    assign in_ready  = rdy_r & rst;
    assign out_valid = vld_r & rst;
    assign out_cnt   = rst ? acc_cnt : '0;
    assign out_data  = rst ? acc : '0;

    assign take = in_valid & in_ready;
    assign clr  = out_valid & out_ready;

`ifdef TMUL_SIGNED_EN
    logic sg_r;
    // The first beat of a tile latches the signedness. Later beats reuse it.
    assign sg_cur = (in_cnt == '0) ? in_signed : sg_r;

    // Hold the signedness chosen on the first beat for the rest of the tile.
    always_ff @(posedge clk) begin
        if (!rst)
            sg_r <= 1'b0;
        else if (take && in_cnt == '0)
            sg_r <= in_signed;
    end
`else
    assign sg_cur = 1'b0;
`endif

    // Per-lane product and accumulate datapath.
    for (genvar i = 0; i < N; i++) begin : g_lane
        tmul_mac_lane #(.DW(DW), .ACCW(ACCW)) u_lane (
            .clk  (clk),
            .rst  (rst),
            .take (take),
            .add  (prod_vld),
            .clr  (clr),
            .sg   (sg_cur),
            .a    (in_a),
            .b    (in_b[i*DW +: DW]),
            .acc  (acc[i])
        );
    end

    // Tile sequencing: accumulate beats, flush the last product, hold the result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_ACC;
            rdy_r    <= 1'b1;
            vld_r    <= 1'b0;
            prod_vld <= 1'b0;
            in_cnt   <= '0;
            acc_cnt  <= '0;
        end else begin
            prod_vld <= take;
            if (prod_vld)
                acc_cnt <= acc_cnt + CW'(1);
            case (state)
                S_ACC: begin
                    if (take) begin
                        in_cnt <= in_cnt + CW'(1);
                        // The K-th beat closes the tile even without in_last.
                        if (in_last || in_cnt == CW'(K-1)) begin
                            state <= S_FLUSH;
                            rdy_r <= 1'b0;
                        end
                    end
                end
                S_FLUSH: begin
                    state <= S_HOLD;
                    vld_r <= 1'b1;
                end
                S_HOLD: begin
                    if (out_ready) begin
                        state   <= S_ACC;
                        rdy_r   <= 1'b1;
                        vld_r   <= 1'b0;
                        in_cnt  <= '0;
                        acc_cnt <= '0;
                    end
                end
                default: begin
                    state <= S_ACC;
                    rdy_r <= 1'b1;
                    vld_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tmul_mac_seq.sv
// tb_tmul_mac_seq: directed self-checking bench for tmul_mac_seq.
// Define TMUL_SIGNED_EN for both bench and design to cover the signed mode.
module tb_tmul_mac_seq;
    localparam int DW   = 32;
    localparam int N    = 8;
    localparam int K    = 8;
    localparam int ACCW = 67;
    localparam int CW   = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DW-1:0]     in_a = '0;
    logic [N*DW-1:0]   in_b = '0;
    logic              in_last = 1'b0;
    logic              in_signed = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [N*ACCW-1:0] out_data;
    logic [CW-1:0]     out_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tmul_mac_seq #(.DW(DW), .N(N), .K(K)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
`ifdef TMUL_SIGNED_EN
        .in_signed (in_signed),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_cnt   (out_cnt)
    );

    // B row with element i = i+1.
    function automatic logic [N*DW-1:0] row_inc();
        logic [N*DW-1:0] r;
        for (int i = 0; i < N; i++) r[i*DW +: DW] = DW'(i + 1);
        return r;
    endfunction

    // B row with every element = v.
    function automatic logic [N*DW-1:0] row_const(input logic [DW-1:0] v);
        logic [N*DW-1:0] r;
        for (int i = 0; i < N; i++) r[i*DW +: DW] = v;
        return r;
    endfunction

    // Present one beat from a falling edge and return just after the accepting edge.
    task automatic send(input logic [DW-1:0] a, input logic [N*DW-1:0] b, input logic last);
        int t;
        t = 0;
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
        #1;
        while (!in_ready && t < 20) begin
            @(negedge clk); #1; t++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL send_timeout: in_ready=%0b required=1", in_ready);
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    // Take the held result: out_ready for exactly one edge.
    task automatic handshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_cnt !== '0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_hold: rdy=%0b vld=%0b cnt=%0d data_nz=%0b required 0/0/0/0",
                     in_ready, out_valid, out_cnt, |out_data);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: rdy=%0b vld=%0b required 1/0", in_ready, out_valid);
        end
    endtask

    // Scenario 1 tile, with the 2-cycle latency check.
    task automatic test_full_tile();
        for (int k = 0; k < K; k++) send(DW'(k + 1), row_inc(), k == K - 1);
        idle(); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_latency_early: out_valid=%0b required=0", out_valid);
        end
        @(negedge clk); #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_latency: out_valid=%0b required=1", out_valid);
        end
        checks++;
        if (out_cnt !== 4'd8) begin
            errors++;
            $display("FAIL full_cnt: got %0d required 8", out_cnt);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (out_data[i*ACCW +: ACCW] !== ACCW'(36 * (i + 1))) begin
                errors++;
                $display("FAIL full_lane%0d: got %0h required %0h", i,
                         out_data[i*ACCW +: ACCW], 36 * (i + 1));
            end
        end
        handshake(); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_after_hs: vld=%0b rdy=%0b required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_early_last();
        for (int k = 0; k < 3; k++) send(DW'(k + 1), row_inc(), k == 2);
        idle();
        @(negedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_cnt !== 4'd3) begin
            errors++;
            $display("FAIL early_cnt: vld=%0b cnt=%0d required 1/3", out_valid, out_cnt);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (out_data[i*ACCW +: ACCW] !== ACCW'(6 * (i + 1))) begin
                errors++;
                $display("FAIL early_lane%0d: got %0h required %0h", i,
                         out_data[i*ACCW +: ACCW], 6 * (i + 1));
            end
        end
        handshake();
    endtask

    task automatic test_width();
        logic [ACCW-1:0] exp;
        exp = 67'h7_FFFF_FFF0_0000_0008;
        for (int k = 0; k < K; k++) send(32'hFFFF_FFFF, row_const(32'hFFFF_FFFF), k == K - 1);
        idle();
        @(negedge clk); #1;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (out_data[i*ACCW +: ACCW] !== exp) begin
                errors++;
                $display("FAIL width_lane%0d: got %0h required %0h", i,
                         out_data[i*ACCW +: ACCW], exp);
            end
        end
        handshake();
    endtask

    task automatic test_forced_last();
        for (int k = 0; k < K; k++) send(32'd1, row_const(32'd1), 1'b0);
        // Keep offering a 9th beat; it must never be taken.
        @(negedge clk);
        in_a = 32'd100; #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL forced_ready: in_ready=%0b required=0", in_ready);
        end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_cnt !== 4'd8 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL forced_hold: vld=%0b cnt=%0d rdy=%0b required 1/8/0",
                     out_valid, out_cnt, in_ready);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (out_data[i*ACCW +: ACCW] !== ACCW'(8)) begin
                errors++;
                $display("FAIL forced_lane%0d: got %0h required 8", i, out_data[i*ACCW +: ACCW]);
            end
        end
        idle();
        handshake();
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < 3; k++) send(DW'(k + 1), row_inc(), k == 2);
        idle();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_cnt !== 4'd3 || in_ready !== 1'b0 ||
                out_data[7*ACCW +: ACCW] !== ACCW'(48) || out_data[0 +: ACCW] !== ACCW'(6)) begin
                errors++;
                $display("FAIL bp_stable c%0d: vld=%0b cnt=%0d rdy=%0b l0=%0h l7=%0h required 1/3/0/6/30",
                         c, out_valid, out_cnt, in_ready, out_data[0 +: ACCW], out_data[7*ACCW +: ACCW]);
            end
        end
        handshake();
        send(32'd1, row_const(32'd1), 1'b1);
        idle();
        @(negedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_cnt !== 4'd1) begin
            errors++;
            $display("FAIL bp_next_cnt: vld=%0b cnt=%0d required 1/1", out_valid, out_cnt);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (out_data[i*ACCW +: ACCW] !== ACCW'(1)) begin
                errors++;
                $display("FAIL bp_next_lane%0d: got %0h required 1", i, out_data[i*ACCW +: ACCW]);
            end
        end
        handshake();
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 4; k++) send(32'd5, row_const(32'd1), 1'b0);
        idle();
        @(negedge clk);
        rst = 1'b0; #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_cnt !== '0 || out_data !== '0) begin
            errors++;
            $display("FAIL rst_mid_hold: rdy=%0b vld=%0b cnt=%0d data_nz=%0b required 0/0/0/0",
                     in_ready, out_valid, out_cnt, |out_data);
        end
        @(negedge clk);
        rst = 1'b1; #1;
        checks++;
        if (in_ready !== 1'b1 || out_cnt !== '0 || out_data !== '0) begin
            errors++;
            $display("FAIL rst_mid_clear: rdy=%0b cnt=%0d data_nz=%0b required 1/0/0",
                     in_ready, out_cnt, |out_data);
        end
        test_full_tile();
        // Reset while a result is held drops it.
        send(32'd1, row_const(32'd1), 1'b1);
        idle();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1; #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_cnt !== '0) begin
            errors++;
            $display("FAIL rst_hold: vld=%0b rdy=%0b cnt=%0d required 0/1/0",
                     out_valid, in_ready, out_cnt);
        end
    endtask

`ifdef TMUL_SIGNED_EN
    task automatic test_signed();
        logic [ACCW-1:0] exp;
        for (int m = 0; m < 2; m++) begin
            exp = (m == 0) ? 67'h7_FFFF_FFFF_FFFF_FFF0 : 67'h0_0000_000F_FFFF_FFF0;
            for (int k = 0; k < K; k++) begin
                // Only the first beat's in_signed counts; flip it afterwards.
                in_signed = (k == 0) ? (m == 0) : (m != 0);
                send(32'hFFFF_FFFF, row_const(32'd2), k == K - 1);
            end
            idle();
            @(negedge clk); #1;
            for (int i = 0; i < N; i++) begin
                checks++;
                if (out_data[i*ACCW +: ACCW] !== exp) begin
                    errors++;
                    $display("FAIL signed%0d_lane%0d: got %0h required %0h", m, i,
                             out_data[i*ACCW +: ACCW], exp);
                end
            end
            handshake();
        end
        in_signed = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_full_tile();
        test_early_last();
        test_width();
        test_forced_last();
        test_backpressure();
        test_reset_mid();
`ifdef TMUL_SIGNED_EN
        test_signed();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not end within 200000 time units");
        $fatal(1);
    end
endmodule
